// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receive-chain definitions: CP ratio codes, CP-stripper state encoding,
// and the CP length helper.
package ofdm_rx_pkg;

    localparam logic [1:0] CP_1_4  = 2'b00;
    localparam logic [1:0] CP_1_8  = 2'b01;
    localparam logic [1:0] CP_1_16 = 2'b10;
    localparam logic [1:0] CP_1_32 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    // CP length in samples for a given ratio code and FFT size.
    function automatic int unsigned cp_len(input logic [1:0] sel, input int unsigned log2Nfft);
        int unsigned sh;
        case (sel)
            CP_1_4:  sh = 2;
            CP_1_8:  sh = 3;
            CP_1_16: sh = 4;
            CP_1_32: sh = 5;
            default: sh = 2;
        endcase
        return (32'd1 << log2Nfft) >> sh;
    endfunction

endpackage

// File: rtl/remove_cp_param_if.sv
// Wishbone-style sample bus seen by the CP stripper (input stream, output stream, CP ratio).
// REMOVE_CP_STATS_EN adds the SYM_CNT_O / DROP_O statistics outputs.
interface remove_cp_param_if #(parameter int DW = 32);
    logic [DW-1:0] DAT_I;
    logic          WE_I;
    logic          STB_I;
    logic          CYC_I;
    logic          ACK_O;
    logic [1:0]    CP_SEL;
    logic [DW-1:0] DAT_O;
    logic          WE_O;
    logic          STB_O;
    logic          CYC_O;
    logic          SOS_O;
    logic          ACK_I;
`ifdef REMOVE_CP_STATS_EN
    logic [15:0]   SYM_CNT_O;
    logic [0:0]    DROP_O;
`endif

    modport slave (
        input  DAT_I, WE_I, STB_I, CYC_I, CP_SEL, ACK_I,
        output ACK_O, DAT_O, WE_O, STB_O, CYC_O, SOS_O
`ifdef REMOVE_CP_STATS_EN
        , output SYM_CNT_O, DROP_O
`endif
    );

    modport master (
        output DAT_I, WE_I, STB_I, CYC_I, CP_SEL, ACK_I,
        input  ACK_O, DAT_O, WE_O, STB_O, CYC_O, SOS_O
`ifdef REMOVE_CP_STATS_EN
        , input SYM_CNT_O, DROP_O
`endif
    );

endinterface

// File: rtl/wb_out_reg.sv
// One-deep Wishbone output register: loads on request, holds data while the sink stalls.
// The caller must only load when the slot is empty or being drained this cycle.
module wb_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] dIn,
    input  logic         ackI,
    output logic         stb,
    output logic [W-1:0] dOut
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb  <= 1'b0;
            dOut <= '0;
        end else if (load) begin
            stb  <= 1'b1;
            dOut <= dIn;
        end else if (ackI) begin
            stb  <= 1'b0;
        end
    end

endmodule

// File: rtl/remove_cp_param.sv
// Parametrised cyclic-prefix remover: drops the CP of each OFDM symbol and forwards NFFT body
// samples with a start-of-symbol flag. Define REMOVE_CP_STATS_EN for symbol/drop statistics.
module remove_cp_param
    import ofdm_rx_pkg::*;
#(
    parameter int         DW         = 32,
    parameter int         LOG2_NFFT  = 8,
    parameter logic [1:0] CP_SEL_RST = 2'b00
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    remove_cp_param_if.slave  bus
);

    localparam int             CW   = LOG2_NFFT + 1;
    localparam logic [CW-1:0]  LAST = CW'((1 << LOG2_NFFT) - 1);
`ifdef REMOVE_CP_STATS_EN
    localparam int             SW   = 2;   // {end-of-symbol, start-of-symbol}
`else
    localparam int             SW   = 1;   // {start-of-symbol}
`endif

    state_t            state, stateN;
    logic [CW-1:0]     cnt, cntN, cpLen;
    logic [1:0]        cpSel, cpSelN;
    logic              xfer, load, stbO, cycO;
    logic [SW-1:0]     sideIn, sideOut;
    logic [DW+SW-1:0]  outWord;

    assign cpLen = CW'(cp_len(cpSel, unsigned'(LOG2_NFFT)));

    // CP samples always flow; body samples wait for a free output slot.
    assign bus.ACK_O = !RST_I && bus.CYC_I && (state != ST_BODY || !stbO || bus.ACK_I);
    assign xfer      = bus.CYC_I && bus.STB_I && bus.WE_I && bus.ACK_O;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cpSel <= CP_SEL_RST;
        end else begin
            state <= stateN;
            cnt   <= cntN;
            cpSel <= cpSelN;
        end
    end

    always_comb begin
        stateN = state;
        cntN   = cnt;
        cpSelN = cpSel;
        load   = 1'b0;
        if (!bus.CYC_I) begin
            stateN = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpSelN = bus.CP_SEL;
                    cntN   = '0;
                    stateN = ST_CP;
                end
                ST_CP: if (xfer) begin
                    if (cnt == cpLen - 1'b1) begin
                        cntN   = '0;
                        stateN = ST_BODY;
                    end else begin
                        cntN = cnt + 1'b1;
                    end
                end
                ST_BODY: if (xfer) begin
                    load = 1'b1;
                    if (cnt == LAST) begin
                        cntN   = '0;
                        cpSelN = bus.CP_SEL;
                        stateN = ST_CP;
                    end else begin
                        cntN = cnt + 1'b1;
                    end
                end
                default: stateN = ST_IDLE;
            endcase
        end
    end

`ifdef REMOVE_CP_STATS_EN
    assign sideIn = {cnt == LAST, cnt == '0};
`else
    assign sideIn = cnt == '0;
`endif

    wb_out_reg #(.W(DW + SW)) u_outReg (
        .clk  (CLK_I),
        .rst  (RST_I),
        .load (load),
        .dIn  ({sideIn, bus.DAT_I}),
        .ackI (bus.ACK_I),
        .stb  (stbO),
        .dOut (outWord)
    );

    assign sideOut   = outWord[DW+SW-1:DW];
    assign bus.DAT_O = outWord[DW-1:0];
    assign bus.SOS_O = sideOut[0];
    assign bus.STB_O = stbO;
    assign bus.WE_O  = cycO;
    assign bus.CYC_O = cycO;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) cycO <= 1'b0;
        else       cycO <= bus.CYC_I | stbO;
    end

`ifdef REMOVE_CP_STATS_EN
    logic        cycFall, partial, dropQ;
    logic [15:0] symCnt;

    // CYC_I low while not idle is exactly the first cycle after its falling edge.
    assign cycFall = !bus.CYC_I && state != ST_IDLE;
    assign partial = state == ST_BODY || (state == ST_CP && cnt != '0);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            symCnt <= '0;
            dropQ  <= 1'b0;
        end else begin
            dropQ <= cycFall && partial;
            if (cycFall)
                symCnt <= '0;
            else if (stbO && bus.ACK_I && sideOut[1])
                symCnt <= symCnt + 16'd1;
        end
    end

    assign bus.SYM_CNT_O = symCnt;
    assign bus.DROP_O    = dropQ;
`endif

endmodule

// File: tb/tb_remove_cp_param.sv
// Directed bench for remove_cp_param: queue-based expected output stream plus literal pins.
module tb_remove_cp_param;
    localparam int DW = 32;
    localparam int LOG2_NFFT = 8;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;

    remove_cp_param_if #(.DW(DW)) bus();

    remove_cp_param #(.DW(DW), .LOG2_NFFT(LOG2_NFFT), .CP_SEL_RST(2'b00)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus.slave)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct { logic [DW-1:0] dat; logic sos; } exp_t;

    int            vecs = 0, errs = 0;
    exp_t          expQ[$];
    exp_t          e;
    int            xferCyc[$];
    logic [DW-1:0] sosLog[$];
    int            cycN = 0, dropCnt = 0;
    int            phase = 0;   // 0 idle, 1 driving a CP sample, 2 driving a body sample
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevDat = '0;
    logic          prevSos = 1'b0;
    bit            toggleEn = 1'b0;
    int            x0, s0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(negedge CLK_I) begin
        cycN++;
        if (RST_I) begin
            prevStall = 1'b0;
        end else begin
            check("we_eq_cyc", bus.WE_O, bus.CYC_O);
            if (prevStall) begin
                check("hold_stb", bus.STB_O, 1);
                check("hold_dat", bus.DAT_O, prevDat);
                check("hold_sos", bus.SOS_O, prevSos);
            end
            if (bus.STB_O && bus.ACK_I) begin
                if (expQ.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL extra_out: got %0d expected no output", bus.DAT_O);
                end else begin
                    e = expQ.pop_front();
                    check("dat", bus.DAT_O, e.dat);
                    check("sos", bus.SOS_O, e.sos);
                end
                xferCyc.push_back(cycN);
                if (bus.SOS_O) sosLog.push_back(bus.DAT_O);
            end
            if (phase == 1 && bus.STB_I) check("ack_cp", bus.ACK_O, 1);
            if (phase == 2 && bus.STB_I) check("ack_body", bus.ACK_O, !(bus.STB_O && !bus.ACK_I));
            prevStall = bus.STB_O && !bus.ACK_I;
            prevDat   = bus.DAT_O;
            prevSos   = bus.SOS_O;
`ifdef REMOVE_CP_STATS_EN
            if (bus.DROP_O) dropCnt++;
`endif
        end
    end

    always @(posedge CLK_I) begin
        if (toggleEn) begin
            #1;
            bus.ACK_I = !bus.ACK_I;
        end
    end

    task automatic sendSample(input logic [DW-1:0] v, input int ph, input bit first);
        bus.DAT_I = v;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        phase     = ph;
        if (ph == 2) expQ.push_back('{v, first});
        for (int k = 0; ; k++) begin
            @(negedge CLK_I);
            if (bus.ACK_O) break;
            if (k >= 300) begin timeout("input_accept"); break; end
        end
        @(posedge CLK_I);
        #1;
        bus.STB_I = 1'b0;
        phase     = 0;
    endtask

    // Drives symbol samples [from,to) with value base+index; the first cp indices are prefix.
    task automatic sendRange(input int base, input int cp, input int from, input int to);
        for (int i = from; i < to; i++)
            sendSample(DW'(base + i), (i < cp) ? 1 : 2, i == cp);
    endtask

    task automatic startFrame();
        bus.CYC_I = 1'b1;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic endFrame();
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK_I);
            if (!bus.CYC_O) break;
        end
        check("cyc_o_fall", bus.CYC_O, 0);
        check("queue_empty", expQ.size(), 0);
        @(posedge CLK_I);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.DAT_I = '0; bus.WE_I = 1'b0; bus.STB_I = 1'b0; bus.CYC_I = 1'b1;
        bus.CP_SEL = 2'b00; bus.ACK_I = 1'b1;
        #1;
        check("rst_ack_o", bus.ACK_O, 0);
        check("rst_stb_o", bus.STB_O, 0);
        check("rst_cyc_o", bus.CYC_O, 0);
        check("rst_dat_o", bus.DAT_O, 0);
        check("rst_sos_o", bus.SOS_O, 0);
        bus.CYC_I = 1'b0;
        waitCycles(2);
        RST_I = 1'b0;
        waitCycles(1);

        // 1: two 288-sample symbols, CP = NFFT/8, no back-pressure
        bus.CP_SEL = 2'b01;
        x0 = xferCyc.size(); s0 = sosLog.size();
        startFrame();
        sendRange(0, 32, 0, 288);
        sendRange(288, 32, 0, 288);
        waitCycles(2);
`ifdef REMOVE_CP_STATS_EN
        check("t1_symcnt", bus.SYM_CNT_O, 2);
`endif
        endFrame();
        check("t1_count", xferCyc.size() - x0, 512);
        if (xferCyc.size() >= x0 + 512) check("t1_span", xferCyc[x0+511] - xferCyc[x0], 543);
        check("t1_nsos", sosLog.size() - s0, 2);
        if (sosLog.size() >= s0 + 2) begin
            check("t1_sos0", sosLog[s0], 32);
            check("t1_sos1", sosLog[s0+1], 320);
        end

        // 2: ratio switched 1/4 -> 1/32 mid-symbol only takes effect on the next symbol
        bus.CP_SEL = 2'b00;
        s0 = sosLog.size();
        startFrame();
        sendRange(1000, 64, 0, 164);
        bus.CP_SEL = 2'b11;
        sendRange(1000, 64, 164, 320);
        sendRange(2000, 8, 0, 264);
        endFrame();
        if (sosLog.size() >= s0 + 2) begin
            check("t2_sos0", sosLog[s0], 1064);
            check("t2_sos1", sosLog[s0+1], 2008);
        end else timeout("t2_sos");

        // 3: ACK_I toggling during the body
        bus.CP_SEL = 2'b10;
        x0 = xferCyc.size(); s0 = sosLog.size();
        startFrame();
        sendRange(3000, 16, 0, 16);
        toggleEn = 1'b1;
        sendRange(3000, 16, 16, 272);
        toggleEn = 1'b0;
        @(posedge CLK_I); #2;
        bus.ACK_I = 1'b1;
        endFrame();
        check("t3_count", xferCyc.size() - x0, 256);
        if (sosLog.size() > s0) check("t3_sos", sosLog[s0], 3016);
        else timeout("t3_sos");

        // 4: ACK_I low through the CP; first body sample is parked on the output
        bus.ACK_I = 1'b0;
        bus.CP_SEL = 2'b11;
        startFrame();
        sendRange(4000, 8, 0, 9);
        repeat (3) begin
            @(negedge CLK_I);
            check("t4_stb", bus.STB_O, 1);
            check("t4_dat", bus.DAT_O, 4008);
            check("t4_sos", bus.SOS_O, 1);
            check("t4_ack_o", bus.ACK_O, 0);
        end
        @(posedge CLK_I); #1;
        bus.ACK_I = 1'b1;
        sendRange(4000, 8, 9, 264);
        endFrame();

        // 5: CYC_I drop after 100 body samples, pending sample drains, then a fresh symbol
        bus.CP_SEL = 2'b01;
        check("t5_drop_before", dropCnt, 0);
        startFrame();
        sendRange(5000, 32, 0, 132);
        bus.ACK_I = 1'b0;
        bus.CYC_I = 1'b0;
        repeat (2) begin
            @(negedge CLK_I);
            check("t5_pend_stb", bus.STB_O, 1);
            check("t5_pend_dat", bus.DAT_O, 5131);
            check("t5_pend_cyc", bus.CYC_O, 1);
        end
        @(posedge CLK_I); #1;
        bus.ACK_I = 1'b1;
        endFrame();
`ifdef REMOVE_CP_STATS_EN
        check("t5_drop_after", dropCnt, 1);
`endif
        startFrame();
        sendRange(6000, 32, 0, 288);
        waitCycles(2);
`ifdef REMOVE_CP_STATS_EN
        check("t5_symcnt", bus.SYM_CNT_O, 1);
`endif
        if (sosLog.size() > 0) check("t5_sos", sosLog[sosLog.size()-1], 6032);
        endFrame();

        // 6: asynchronous reset mid-body between clock edges
        bus.CP_SEL = 2'b00;
        startFrame();
        sendRange(7000, 64, 0, 100);
        #2;
        RST_I = 1'b1;
        #1;
        check("t6_stb_o", bus.STB_O, 0);
        check("t6_cyc_o", bus.CYC_O, 0);
        check("t6_ack_o", bus.ACK_O, 0);
        check("t6_dat_o", bus.DAT_O, 0);
        check("t6_sos_o", bus.SOS_O, 0);
        expQ.delete();
        bus.CYC_I = 1'b0;
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        waitCycles(1);
        s0 = sosLog.size();
        startFrame();
        sendRange(8000, 64, 0, 320);
        endFrame();
        if (sosLog.size() > s0) check("t6_sos", sosLog[s0], 8064);
        else timeout("t6_sos");

        waitCycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
